// File: rtl/sonic_cmd_ctl_mp.sv
// Multi-port SoNIC command controller: decodes host prg-reg commands, drives per-port
// soft reset / enable and irq register-file writes, and returns one response per command.

module sonic_port_ctl (
  input  logic clk_in,
  input  logic rstn,
  input  logic rst_on,
  input  logic rst_off,
  input  logic en_set,
  input  logic en_clr,
  output logic soft_resetn,
  output logic enable_sfp
);
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      soft_resetn <= 1'b1;
      enable_sfp  <= 1'b0;
    end else begin
      if (rst_on)       soft_resetn <= 1'b0;
      else if (rst_off) soft_resetn <= 1'b1;
      if (en_set)       enable_sfp <= 1'b1;
      else if (en_clr)  enable_sfp <= 1'b0;
    end
  end
endmodule

module sonic_cmd_ctl_mp #(
  parameter int NUM_PORTS    = 2,
  parameter int RING_SIZE    = 8192,
  parameter int RESET_CYCLES = 4,
  parameter int PORT_W       = 4
) (
  input  logic                    clk_in,
  input  logic                    rstn,
  input  logic                    cmd_prg_wrena,
  input  logic [31:0]             cmd_prg_wrdata,
  input  logic [7:0]              cmd_prg_addr,
  output logic [31:0]             cmd_prg_rddata,
  output logic [NUM_PORTS-1:0]    soft_resetn,
  output logic [NUM_PORTS-1:0]    enable_sfp,
  output logic                    irq_prg_wrena,
  output logic [31:0]             irq_prg_wrdata,
  output logic [7:0]              irq_prg_addr,
  output logic [PORT_W-1:0]       irq_prg_port,
  input  logic [NUM_PORTS*32-1:0] rx_block_size,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [63:0]             resp_data,
  output logic [63:0]             resp_err,
  output logic                    busy
);
  typedef enum logic [2:0] {IDLE, CHECK, EXECUTE, WRITEBACK, RESP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] err;
  } resp_t;

  localparam logic [7:0]  OP_RESET = 8'd1, OP_START = 8'd2, OP_STOP = 8'd3;
  localparam logic [7:0]  OP_RING = 8'd4, OP_GETRX = 8'd5, OP_SETADDR = 8'd6;
  localparam logic [7:0]  OP_CFGIRQ = 8'd7, OP_SETRX = 8'd8;
  localparam logic [7:0]  A_CMD = 8'd0, A_P0 = 8'd1, A_P1 = 8'd2, A_STAT = 8'd3;
  localparam logic [31:0] NP      = NUM_PORTS;
  localparam logic [31:0] RST_LEN = RESET_CYCLES;
  localparam logic [63:0] RING_L  = 64'(RING_SIZE);

  state_t            state;
  resp_t             resp_q;
  logic [31:0]       cmd_reg, param0, param1, rx_cap, cyc;
  logic [31:0]       exec_len, nxt_cyc, rx_sel, irq_d;
  logic [7:0]        opcode, irq_a;
  logic [PORT_W-1:0] port;
  logic [3:0]        err_q, chk_err, last_err;
  logic [63:0]       get_val;
  logic              overrun, irq_go, adv, ctl_go, ctl_done;

  assign opcode     = cmd_reg[7:0];
  assign port       = cmd_reg[8 +: PORT_W];
  assign busy       = (state != IDLE);
  assign resp_data  = resp_q.data;
  assign resp_err   = resp_q.err;

  always_comb begin
    chk_err = 4'd0;
    if (opcode > OP_SETRX)                           chk_err = 4'd2;
    else if ({{(32-PORT_W){1'b0}}, port} >= NP)      chk_err = 4'd3;
  end

  always_comb begin
    case (opcode)
      OP_RESET:   exec_len = RST_LEN;
      OP_SETADDR: exec_len = 32'd2;
      default:    exec_len = 32'd1;
    endcase
  end

  // irq write for the EXECUTE cycle about to start; registered on entry to that cycle
  assign nxt_cyc  = (state == CHECK) ? 32'd1 : cyc + 32'd1;
  assign ctl_go   = (state == CHECK) && (chk_err == 4'd0);
  assign ctl_done = (state == EXECUTE) && (cyc >= exec_len);
  assign adv      = ctl_go || ((state == EXECUTE) && (cyc < exec_len));

  always_comb begin
    irq_go = 1'b0;
    irq_a  = 8'd0;
    irq_d  = 32'd0;
    case (opcode)
      OP_SETADDR: begin
        if (nxt_cyc == 32'd1)      begin irq_go = 1'b1; irq_a = 8'd1; irq_d = param0; end
        else if (nxt_cyc == 32'd2) begin irq_go = 1'b1; irq_a = 8'd2; irq_d = param1; end
      end
      OP_CFGIRQ: if (nxt_cyc == 32'd1) begin irq_go = 1'b1; irq_a = 8'd0; irq_d = param0; end
      OP_SETRX:  if (nxt_cyc == 32'd1) begin irq_go = 1'b1; irq_a = 8'd3; irq_d = param0; end
      default: ;
    endcase
  end

  always_comb begin
    rx_sel = 32'd0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (port == PORT_W'(p)) rx_sel = rx_block_size[32*p +: 32];
  end

  always_comb begin
    case (opcode)
      OP_RING:  get_val = RING_L;
      OP_GETRX: get_val = {32'd0, rx_cap};
      default:  get_val = 64'd0;
    endcase
  end

  always_comb begin
    case (cmd_prg_addr)
      A_CMD:   cmd_prg_rddata = cmd_reg;
      A_P0:    cmd_prg_rddata = param0;
      A_P1:    cmd_prg_rddata = param1;
      A_STAT:  cmd_prg_rddata = {23'd0, overrun, 4'd0, last_err};
      default: cmd_prg_rddata = 32'd0;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic sel;
    assign sel = (port == PORT_W'(p));
    sonic_port_ctl u_port (
      .clk_in      (clk_in),
      .rstn        (rstn),
      .rst_on      (sel && ctl_go && (opcode == OP_RESET)),
      .rst_off     (sel && ctl_done && (opcode == OP_RESET)),
      .en_set      (sel && ctl_go && (opcode == OP_START)),
      .en_clr      (sel && ctl_go && (opcode == OP_STOP)),
      .soft_resetn (soft_resetn[p]),
      .enable_sfp  (enable_sfp[p])
    );
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cmd_reg        <= 32'd0;
      param0         <= 32'd0;
      param1         <= 32'd0;
      overrun        <= 1'b0;
      last_err       <= 4'd0;
      err_q          <= 4'd0;
      cyc            <= 32'd0;
      rx_cap         <= 32'd0;
      resp_valid     <= 1'b0;
      resp_q         <= '0;
      irq_prg_wrena  <= 1'b0;
      irq_prg_wrdata <= 32'd0;
      irq_prg_addr   <= 8'd0;
      irq_prg_port   <= '0;
    end else begin
      irq_prg_wrena  <= 1'b0;
      irq_prg_wrdata <= 32'd0;
      irq_prg_addr   <= 8'd0;
      irq_prg_port   <= '0;
      if (adv && irq_go) begin
        irq_prg_wrena  <= 1'b1;
        irq_prg_wrdata <= irq_d;
        irq_prg_addr   <= irq_a;
        irq_prg_port   <= port;
      end

      if (cmd_prg_wrena) begin
        if (cmd_prg_addr == A_STAT) begin
          if (cmd_prg_wrdata[8]) overrun <= 1'b0;
        end else if (cmd_prg_addr <= A_P1) begin
          if (busy)                      overrun <= 1'b1;
          else if (cmd_prg_addr == A_P0) param0  <= cmd_prg_wrdata;
          else if (cmd_prg_addr == A_P1) param1  <= cmd_prg_wrdata;
        end
      end

      case (state)
        IDLE: if (cmd_prg_wrena && (cmd_prg_addr == A_CMD)) begin
          cmd_reg <= cmd_prg_wrdata;
          if (cmd_prg_wrdata[7:0] != 8'd0) state <= CHECK;
        end
        CHECK: begin
          err_q <= chk_err;
          cyc   <= 32'd1;
          state <= (chk_err == 4'd0) ? EXECUTE : WRITEBACK;
        end
        EXECUTE: begin
          if (cyc == 32'd1) rx_cap <= rx_sel;
          if (cyc >= exec_len) state <= WRITEBACK;
          else                 cyc   <= cyc + 32'd1;
        end
        WRITEBACK: begin
          cmd_reg     <= 32'd0;
          last_err    <= err_q;
          resp_q.err  <= {60'd0, err_q};
          resp_q.data <= (err_q == 4'd0) ? get_val : 64'd0;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sonic_cmd_ctl_mp.md
Name: sonic_cmd_ctl_mp

Overview:
Multi-port SoNIC command controller, the successor to the two-SFP command controller. It is generalised to NUM_PORTS ports, with per-port enable and soft reset, a configurable reset pulse length, and explicit error reporting. Host writes arrive over the prg-reg interface from the RC slave. Commands execute here and drive per-port control and the irq-generator register file. Each command produces one response that is handed to the RC update engine over a valid/ready handshake.

Parameters:
NUM_PORTS, 2, number of SFP ports (1..16)
RING_SIZE, 8192, ring size returned by GET_RING_SIZE
RESET_CYCLES, 4, soft reset pulse length in cycles (>=1)
PORT_W, 4, width of the port index field

Ports:
clk_in  in  1  clock
rstn  in  1  reset
cmd_prg_wrena  in  1  host register write strobe
cmd_prg_wrdata  in  32  host write data
cmd_prg_addr  in  8  register address: 0 CMD, 1 PARAM0, 2 PARAM1, 3 STATUS
cmd_prg_rddata  out  32  combinational read data for cmd_prg_addr
soft_resetn  out  NUM_PORTS  per-port soft reset, active-low
enable_sfp  out  NUM_PORTS  per-port enable
irq_prg_wrena  out  1  irq register-file write strobe
irq_prg_wrdata  out  32  irq write data
irq_prg_addr  out  8  irq register address (DW0..DW3 = 0..3)
irq_prg_port  out  PORT_W  target port of the irq write
rx_block_size  in  NUM_PORTS*32  per-port rx block size; port p occupies [32p+31:32p]
resp_valid  out  1  response available
resp_ready  in  1  RC update engine accepts the response
resp_data  out  64  response payload
resp_err  out  64  response error code
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is asynchronous, active-low on rstn.
  - On reset: all registers are 0, soft_resetn is all ones, enable_sfp is 0, irq_prg_wrena is 0, resp_valid is 0, busy is 0, state is IDLE.
- CMD word layout: opcode in [7:0], port in [8+PORT_W-1:8].
- Opcodes:
  - 0 NONE
  - 1 RESET
  - 2 START
  - 3 STOP
  - 4 GET_RING_SIZE
  - 5 GET_RX_BLOCK_SIZE
  - 6 SET_ADDR_IRQ
  - 7 CONFIG_IRQ
  - 8 SET_RX_BLOCK_SIZE
- Write acceptance:
  - PARAM0/PARAM1 writes are accepted only in IDLE.
  - A CMD write in IDLE latches the CMD word.
  - Any CMD or PARAM write while busy is dropped and sets sticky overrun (STATUS[8]).
  - A write of 1 to STATUS[8] clears overrun.
- STATUS read value: {23'b0, overrun, 4'b0, last_err[3:0]}.
- FSM states: IDLE, CHECK, EXECUTE, WRITEBACK, RESP.
- IDLE:
  - A CMD write at edge T with opcode != 0 puts the FSM in CHECK from edge T+1.
  - Opcode 0 is ignored.
- CHECK (1 cycle) computes err:
  - 2 if the opcode is >8.
  - Otherwise 3 if port >= NUM_PORTS.
  - Otherwise 0.
  - err != 0 goes to WRITEBACK, skipping EXECUTE; err == 0 goes to EXECUTE.
- EXECUTE:
  - cycle counter starts at 1 on the first EXECUTE cycle.
  - RESET: soft_resetn[port] is 0 for exactly RESET_CYCLES cycles. Other ports are unaffected.
  - START: sets enable_sfp[port] (1 cycle).
  - STOP: clears enable_sfp[port] (1 cycle).
  - GET_RING_SIZE: resp_data = RING_SIZE, zero-extended.
  - GET_RX_BLOCK_SIZE: resp_data = rx_block_size of port, sampled in cycle 1.
  - SET_ADDR_IRQ (2 cycles): cycle 1 writes PARAM0 to DW1; cycle 2 writes PARAM1 to DW2.
  - CONFIG_IRQ (1 cycle): writes PARAM0 to DW0.
  - SET_RX_BLOCK_SIZE (1 cycle): writes PARAM0 to DW3.
  - Each irq write is a single registered strobe carrying irq_prg_port = port.
  - Outside an irq write, irq_prg_wrena, irq_prg_wrdata and irq_prg_addr are 0.
- WRITEBACK (1 cycle):
  - Clears the CMD register to 0.
  - last_err <= err.
  - Loads resp_err = err, zero-extended.
  - resp_data is 0 unless the opcode is a GET.
- RESP:
  - resp_valid stays high and resp_data/resp_err stay stable until resp_ready is sampled high.
  - When resp_ready is sampled high, the FSM returns to IDLE the next cycle and resp_valid drops.
  - resp_ready high in the same cycle resp_valid rises completes the transfer in 1 cycle.
- Reset mid-operation:
  - Aborts the command with no response.
  - Restores all reset values, including enable_sfp = 0.
- Simultaneous events: a host CMD write in the cycle the FSM re-enters IDLE is accepted; it is not dropped.

Test Plan:
- Write CMD=0x0102 (START, port 1), then resp_ready=1 -> enable_sfp=2'b10; one response with data 0, err 0; busy low after 4 cycles.
- Write CMD=0x0001 (RESET, port 0), RESET_CYCLES=4 -> soft_resetn[0] low for exactly 4 cycles; soft_resetn[1] stays high; err 0.
- Write PARAM0=0xDEAD0000, PARAM1=0x0000BEEF, CMD=0x0106 -> two irq strobes, port=1: (DW1, 0xDEAD0000), then (DW2, 0x0000BEEF).
- Write CMD=0x0205 with NUM_PORTS=2 -> no EXECUTE; resp_err=3; STATUS[3:0]=3.
- Write CMD=0x0004 with resp_ready held 0 for 10 cycles, plus a CMD write during the stall -> resp_valid held with data 8192 stable; dropped write sets STATUS[8]; writing 0x100 to STATUS clears it.
- Deassert rstn during RESET, EXECUTE cycle 2 -> soft_resetn all ones immediately; resp_valid 0; enable_sfp 0; next command executes normally.
